// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory bus port between IF fetch and MEM load/store; MEM priority with IF starvation guard.
// Latency: gnt combinational in IDLE, bus_req next cycle, response registered one cycle after bus_rvalid.
// Backpressure: requesters hold req until gnt; bus_req held until ack. ARB_PERF_CNT_EN adds perf counters.
module ysyx_22040386_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_ARB_clk,
  input  logic                  i_ARB_rst_n,
  input  logic                  i_ARB_if_req,
  input  logic [ADDR_W-1:0]     i_ARB_if_addr,
  input  logic                  i_ARB_if_flush,
  output logic                  o_ARB_if_gnt,
  output logic                  o_ARB_if_rvalid,
  output logic [DATA_W-1:0]     o_ARB_if_rdata,
  input  logic                  i_ARB_mem_req,
  input  logic                  i_ARB_mem_wen,
  input  logic [ADDR_W-1:0]     i_ARB_mem_addr,
  input  logic [DATA_W-1:0]     i_ARB_mem_wdata,
  input  logic [DATA_W/8-1:0]   i_ARB_mem_wmask,
  output logic                  o_ARB_mem_gnt,
  output logic                  o_ARB_mem_rvalid,
  output logic [DATA_W-1:0]     o_ARB_mem_rdata,
  output logic                  o_ARB_bus_req,
  output logic                  o_ARB_bus_wen,
  output logic [ADDR_W-1:0]     o_ARB_bus_addr,
  output logic [DATA_W-1:0]     o_ARB_bus_wdata,
  output logic [DATA_W/8-1:0]   o_ARB_bus_wmask,
  input  logic                  i_ARB_bus_ack,
  input  logic                  i_ARB_bus_rvalid,
  input  logic [DATA_W-1:0]     i_ARB_bus_rdata,
  output logic                  o_ARB_busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           o_ARB_perf_if_gnt,
  output logic [31:0]           o_ARB_perf_mem_gnt,
  output logic [31:0]           o_ARB_perf_if_stall
`endif
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                owner_if_q, owner_if_d;
  logic                drop_q, drop_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                mem_rvalid_q, mem_rvalid_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic                mem_win, if_win;
  logic                if_gnt_c, mem_gnt_c;
  logic                rsp_fire;

  // IF is forced through only when it is actually waiting and has lost STARVE_MAX times in a row.
  assign mem_win = i_ARB_mem_req && !(i_ARB_if_req && (starve_q == STARVE_LIM));
  assign if_win  = !mem_win && i_ARB_if_req;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    owner_if_d = owner_if_q;
    drop_d     = drop_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_gnt_c   = 1'b0;
    mem_gnt_c  = 1'b0;
    rsp_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_win) begin
          mem_gnt_c  = 1'b1;
          owner_if_d = 1'b0;
          drop_d     = 1'b0;
          wen_d      = i_ARB_mem_wen;
          addr_d     = i_ARB_mem_addr;
          wdata_d    = i_ARB_mem_wdata;
          wmask_d    = i_ARB_mem_wmask;
          state_d    = ST_REQ;
          if (i_ARB_if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (if_win) begin
          if_gnt_c   = 1'b1;
          owner_if_d = 1'b1;
          drop_d     = i_ARB_if_flush;
          wen_d      = 1'b0;
          addr_d     = i_ARB_if_addr;
          wdata_d    = '0;
          wmask_d    = '0;
          starve_d   = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (owner_if_q && i_ARB_if_flush) begin
          drop_d = 1'b1;
        end
        // A response without acceptance is not a valid bus event and is ignored.
        if (i_ARB_bus_ack) begin
          rsp_fire = i_ARB_bus_rvalid;
          state_d  = i_ARB_bus_rvalid ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (owner_if_q && i_ARB_if_flush) begin
          drop_d = 1'b1;
        end
        if (i_ARB_bus_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // drop_d already folds in a flush seen in the response cycle itself.
  always_comb begin
    if_rvalid_d  = rsp_fire && owner_if_q && !drop_d;
    mem_rvalid_d = rsp_fire && !owner_if_q;
    if_rdata_d   = if_rvalid_d ? i_ARB_bus_rdata : '0;
    mem_rdata_d  = (mem_rvalid_d && !wen_q) ? i_ARB_bus_rdata : '0;
  end

  always_ff @(posedge i_ARB_clk) begin
    if (!i_ARB_rst_n) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      owner_if_q   <= 1'b0;
      drop_q       <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      owner_if_q   <= owner_if_d;
      drop_q       <= drop_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // Grants are combinational from the request inputs, so they are masked while reset is held.
  assign o_ARB_if_gnt     = i_ARB_rst_n && if_gnt_c;
  assign o_ARB_mem_gnt    = i_ARB_rst_n && mem_gnt_c;
  assign o_ARB_if_rvalid  = if_rvalid_q;
  assign o_ARB_if_rdata   = if_rdata_q;
  assign o_ARB_mem_rvalid = mem_rvalid_q;
  assign o_ARB_mem_rdata  = mem_rdata_q;
  assign o_ARB_bus_req    = (state_q == ST_REQ);
  assign o_ARB_bus_wen    = wen_q;
  assign o_ARB_bus_addr   = addr_q;
  assign o_ARB_bus_wdata  = wdata_q;
  assign o_ARB_bus_wmask  = wmask_q;
  assign o_ARB_busy       = (state_q != ST_IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_gnt_q, perf_mem_gnt_q, perf_if_stall_q;

  always_ff @(posedge i_ARB_clk) begin
    if (!i_ARB_rst_n) begin
      perf_if_gnt_q   <= '0;
      perf_mem_gnt_q  <= '0;
      perf_if_stall_q <= '0;
    end else begin
      if (if_gnt_c) begin
        perf_if_gnt_q <= perf_if_gnt_q + 32'd1;
      end
      if (mem_gnt_c) begin
        perf_mem_gnt_q <= perf_mem_gnt_q + 32'd1;
      end
      if (i_ARB_if_req && !if_gnt_c) begin
        perf_if_stall_q <= perf_if_stall_q + 32'd1;
      end
    end
  end

  assign o_ARB_perf_if_gnt   = perf_if_gnt_q;
  assign o_ARB_perf_mem_gnt  = perf_mem_gnt_q;
  assign o_ARB_perf_if_stall = perf_if_stall_q;
`endif

endmodule
